// File: rtl/vec_operand_reader.sv
// vec_operand_reader: streams the packets of one vector register out of the register file,
// throttling reads by FIFO credit so the output buffer never overflows.
module vec_operand_reader #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 64,
    parameter int OFF_BITS     = 8,
    parameter int PACK_PER_REG = 256,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [OFF_BITS:0]     req_len,
    output logic                  rf_rd_en,
    output logic [ADDR_WIDTH-1:0] rf_rd_addr,
    output logic [OFF_BITS-1:0]   rf_rd_off,
    input  logic [DATA_WIDTH-1:0] rf_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = OFF_BITS + 1;
    localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2;
    localparam logic [LW-1:0] MAX_LEN = LW'(PACK_PER_REG);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LW-1:0]         len_q, len_d, off_q, off_d;
    logic                  inflight_q, inflight_last_q;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PW:0]           count_q;
    logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_q;
    logic                  hs, issue, issue_last, push, pop;

    assign req_ready  = state_q == IDLE;
    assign busy       = state_q != IDLE;
    assign hs         = req_valid && req_ready;
    // Credit counts the read whose data lands next edge, so a full FIFO can never be pushed.
    assign issue      = state_q == READ && off_q < len_q && (int'(count_q) + int'(inflight_q)) < FIFO_DEPTH;
    assign issue_last = issue && off_q == len_q - LW'(1);
    assign push       = inflight_q;
    assign pop        = out_valid && out_ready;
    assign rf_rd_en   = issue;
    assign rf_rd_addr = addr_q;
    assign rf_rd_off  = off_q[OFF_BITS-1:0];
    assign out_valid  = count_q != '0;
    assign out_data   = data_q[rd_ptr_q];
    assign out_last   = out_valid && last_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        off_d   = off_q;
        if (hs) begin
            addr_d  = req_addr;
            len_d   = req_len > MAX_LEN ? MAX_LEN : req_len;
            off_d   = '0;
            state_d = READ;
        end else if (state_q == READ) begin
            off_d   = issue ? off_q + LW'(1) : off_q;
            state_d = len_q == '0 ? IDLE : issue_last ? DRAIN : READ;
        end else if (state_q == DRAIN && pop && out_last) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            len_q           <= '0;
            off_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            len_q           <= len_d;
            off_q           <= off_d;
            inflight_q      <= issue;
            inflight_last_q <= issue_last;
            wr_ptr_q        <= push ? wr_ptr_q + PW'(1) : wr_ptr_q;
            rd_ptr_q        <= pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
            count_q         <= count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= rf_rd_data;
            last_q[wr_ptr_q] <= inflight_last_q;
        end
    end
endmodule

// File: tb/tb_vec_operand_reader.sv
// tb_vec_operand_reader: directed vector table plus hand-written latency, stall, reset and back-to-back sequences.
module tb_vec_operand_reader;
    logic        clk = 0, rst = 1, req_valid = 0, out_ready = 0;
    logic [4:0]  req_addr = '0;
    logic [8:0]  req_len = '0;
    logic        req_ready, rf_rd_en, out_valid, out_last, busy;
    logic [4:0]  rf_rd_addr;
    logic [7:0]  rf_rd_off;
    logic [63:0] rf_rd_data = '0, out_data;
    int total = 0, bad = 0;

    typedef struct { int addr; int len; int n; int mode; } vec_t;
    vec_t vecs[6];

    vec_operand_reader dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .rf_rd_en(rf_rd_en),
        .rf_rd_addr(rf_rd_addr), .rf_rd_off(rf_rd_off), .rf_rd_data(rf_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input int a, input int o);
        return {16'hBEEF, 16'(a), 32'(o)};
    endfunction

    // Register file model: data appears the cycle after the read enable.
    always @(posedge clk) if (rf_rd_en) rf_rd_data <= pat(int'(rf_rd_addr), int'(rf_rd_off));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic issue(input int a, input int l, output int waits);
        waits = 0;
        req_addr = 5'(a);
        req_len = 9'(l);
        req_valid = 1;
        while (!req_ready && waits < 50) begin
            step();
            waits++;
        end
        if (!req_ready) fail("req_accept");
        step();
        req_valid = 0;
    endtask

    task automatic collect(input int a, input int n, input int mode, input int rd0);
        int got = 0, rd = rd0, cyc = 0;
        bit done = 0;
        while (!done && cyc < 2000) begin
            out_ready = mode == 0 ? 1'b1 : (cyc % 2 == 0);
            if (rf_rd_en) begin
                chk("rd_off", 64'(rf_rd_off), 64'(rd));
                chk("rd_addr", 64'(rf_rd_addr), 64'(a));
                rd++;
            end
            if (out_valid && out_ready) begin
                chk("data", out_data, pat(a, got));
                chk("last", 64'(out_last), 64'(got == n - 1));
                got++;
                done = out_last;
            end
            step();
            cyc++;
        end
        if (!done) fail("collect_last");
        chk("pkt_count", 64'(got), 64'(n));
        chk("read_count", 64'(rd), 64'(n));
        chk("idle_after", 64'({req_ready, busy}), 64'(2'b10));
    endtask

    initial begin
        int w, rd, stray;
        vecs[0] = '{3, 4, 4, 0};
        vecs[1] = '{1, 1, 1, 0};
        vecs[2] = '{7, 5, 5, 1};
        vecs[3] = '{31, 300, 256, 0};
        vecs[4] = '{0, 256, 256, 1};
        vecs[5] = '{5, 17, 17, 1};

        step();
        chk("rst_outs", 64'({rf_rd_en, out_valid, out_last, busy}), 64'(0));
        chk("rst_addr_off", 64'({rf_rd_addr, rf_rd_off}), 64'(0));
        rst = 0;
        step();
        chk("rst_ready", 64'(req_ready), 64'(1));

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].addr, vecs[i].len, w);
            collect(vecs[i].addr, vecs[i].n, vecs[i].mode, 0);
        end

        issue(3, 4, w);
        for (int k = 1; k <= 7; k++) begin
            out_ready = 1;
            chk("lat_rd_en", 64'(rf_rd_en), 64'(k <= 4));
            if (k <= 4) chk("lat_rd_off", 64'(rf_rd_off), 64'(k - 1));
            chk("lat_valid", 64'(out_valid), 64'(k >= 3 && k <= 6));
            chk("lat_last", 64'(out_last), 64'(k == 6));
            if (k >= 3 && k <= 6) chk("lat_data", out_data, pat(3, k - 3));
            if (k == 7) chk("lat_ready", 64'(req_ready), 64'(1));
            step();
        end

        issue(6, 8, w);
        out_ready = 0;
        rd = 0;
        for (int i = 0; i < 10; i++) begin
            if (rf_rd_en) rd++;
            if (i >= 2) chk("stall_data", {63'(0), out_valid} ^ out_data, {63'(0), 1'b1} ^ pat(6, 0));
            step();
        end
        chk("stall_reads", 64'(rd), 64'(4));
        collect(6, 8, 0, 4);

        issue(9, 0, w);
        chk("len0_t1", 64'({busy, rf_rd_en, out_valid}), 64'(3'b100));
        step();
        chk("len0_t2", 64'({req_ready, rf_rd_en, out_valid}), 64'(3'b100));

        issue(1, 2, w);
        collect(1, 2, 0, 0);
        issue(2, 2, w);
        chk("b2b_wait", 64'(w), 64'(0));
        collect(2, 2, 0, 0);

        issue(12, 8, w);
        out_ready = 0;
        step();
        step();
        step();
        chk("mid_state", 64'({out_valid, rf_rd_en, busy}), 64'(3'b111));
        rst = 1;
        #1;
        chk("mid_rst", 64'({out_valid, busy, rf_rd_en, out_last}), 64'(0));
        step();
        rst = 0;
        out_ready = 1;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid || rf_rd_en) stray++;
            step();
        end
        chk("stray", 64'(stray), 64'(0));
        chk("post_rst_ready", 64'(req_ready), 64'(1));
        issue(4, 3, w);
        collect(4, 3, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vec_operand_reader.md
VEC_OPERAND_READER -- requirements
Module: vec_operand_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, vector register index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, packet width in bits.
REQ-003 SHALL have parameter OFF_BITS, default 8, packet offset width.
REQ-004 SHALL have parameter PACK_PER_REG, default 256, packets per vector register.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of 2, >=4).
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port req_valid  input  1  read request valid.
REQ-009 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-010 SHALL have port req_addr  input  ADDR_WIDTH  vector register to read.
REQ-011 SHALL have port req_len  input  OFF_BITS+1  packet count to read.
REQ-012 SHALL have port rf_rd_en  output  1  register file read enable.
REQ-013 SHALL have port rf_rd_addr  output  ADDR_WIDTH  register file read address.
REQ-014 SHALL have port rf_rd_off  output  OFF_BITS  register file packet offset.
REQ-015 SHALL have port rf_rd_data  input  DATA_WIDTH  register file read data, valid one cycle after rf_rd_en.
REQ-016 SHALL have port out_valid  output  1  output packet valid.
REQ-017 SHALL have port out_ready  input  1  downstream accepts packet.
REQ-018 SHALL have port out_data  output  DATA_WIDTH  output packet.
REQ-019 SHALL have port out_last  output  1  marks final packet of a request.
REQ-020 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-021 SHALL implement states IDLE, READ, DRAIN; req_ready=1 only in IDLE.
REQ-022 SHALL on request handshake latch req_addr and eff_len = min(req_len, PACK_PER_REG), clear the offset counter, go to READ.
REQ-023 SHALL treat eff_len=0 as a no-op: no rf_rd_en, no output, IDLE->READ->IDLE with READ lasting one cycle.
REQ-024 SHALL in READ assert rf_rd_en iff fifo_count + inflight < FIFO_DEPTH, where inflight is 1 when rf_rd_en was high the previous cycle.
REQ-025 SHALL drive rf_rd_addr = latched address and rf_rd_off = offset counter; offset increments on each issued read.
REQ-026 SHALL leave READ for DRAIN in the cycle after issuing offset eff_len-1.
REQ-027 SHALL push rf_rd_data into the FIFO at the clock edge ending the cycle after an issued read, tagging last when its offset was eff_len-1.
REQ-028 SHALL present FIFO head on out_data/out_last with out_valid = FIFO non-empty; pop on out_valid && out_ready.
REQ-029 SHALL hold out_data/out_last stable while out_valid && !out_ready.
REQ-030 SHALL allow simultaneous push and pop with count unchanged; credit rule guarantees no overflow.
REQ-031 SHALL go DRAIN->IDLE at the edge popping the last-tagged packet; next request handshake possible the following cycle.
REQ-032 SHALL give latency: handshake edge at cycle T, first rf_rd_en in T+1, first out_valid in T+3.
REQ-033 SHALL sustain one packet per cycle when out_ready is held high.
REQ-034 SHALL issue offsets strictly in order 0..eff_len-1 and deliver packets in the same order.

Reset
REQ-035 SHALL on rst force IDLE, clear offset, inflight, FIFO pointers and count; outputs: req_ready=1 after release, rf_rd_en=0, out_valid=0, out_last=0, busy=0, rf_rd_addr=0, rf_rd_off=0.
REQ-036 SHALL on reset mid-request discard in-flight read data; no packet from the aborted request appears after release.

Verification
REQ-037 SHALL cover: req_addr=3, req_len=4, out_ready=1 -> rf_rd_off 0,1,2,3 on consecutive cycles from T+1, out_valid T+3..T+6, out_last only at T+6.
REQ-038 SHALL cover: req_len=8, out_ready=0 for 10 cycles -> exactly 4 reads issued, out_data frozen on packet 0, then 8 packets in order after release.
REQ-039 SHALL cover: req_len=0 -> no rf_rd_en, no out_valid, req_ready high again within 2 cycles.
REQ-040 SHALL cover: req_len=300 -> exactly 256 packets, out_last on offset 255.
REQ-041 SHALL cover: rst asserted while 2 packets buffered and 1 in flight -> out_valid=0 and busy=0 immediately, no stray packet after release.
REQ-042 SHALL cover: back-to-back requests len=2 to regs 1 then 2 -> second accepted one cycle after first out_last pop, data ordered reg1[0],reg1[1],reg2[0],reg2[1].
